// File: rtl/bcd_codes_pkg.sv
// Shared BCD / 2421 (Aiken) code definitions.
// The encoder uses these now; the 2421->BCD decoder will use them later.
package bcd_codes_pkg;
   typedef logic [3:0] bcd_t;
   typedef logic [3:0] code2421_t;

   localparam bcd_t BCD_MAX = 4'd9;

   // 2421 weights are 2,4,2,1 (wxyz). Entries 5..9 are the bitwise complements of 4..0.
   localparam code2421_t CODE_TABLE [10] = '{
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111
   };

   function automatic logic is_bcd(input bcd_t d);
      return (d <= BCD_MAX);
   endfunction
endpackage

// File: rtl/bcd_to_2421_if.sv
// Digit-in / code-out bundle for the BCD -> 2421 encoder.
// valid-only handshake: the source drives data with in_valid high for one clock per digit;
// there is no ready, so the sink must accept every out_valid pulse as it appears.
interface bcd_to_2421_if;
   import bcd_codes_pkg::*;

   bcd_t data;
   logic in_valid;
   logic w;
   logic x;
   logic y;
   logic z;
   logic out_valid;
   logic err;

   modport master (
      output data, in_valid,
      input  w, x, y, z, out_valid, err
   );

   modport slave (
      input  data, in_valid,
      output w, x, y, z, out_valid, err
   );
endinterface

// File: rtl/bcd2421_lut.sv
// Combinational BCD digit -> 2421 code lookup.
// Non-BCD digits give code 0000 with invalid raised.
module bcd2421_lut
   import bcd_codes_pkg::*;
(
   input  bcd_t      data,
   output code2421_t code,
   output logic      invalid
);

   always_comb begin
      invalid = 1'b0;
      code    = '0;
      if (is_bcd(data)) begin
         code = CODE_TABLE[data];
      end else begin
         invalid = 1'b1;
      end
   end

endmodule

// File: rtl/bcd_to_2421.sv
// Registered BCD -> 2421 encoder: one digit per clock, one clock of latency.
// Input is qualified by in_valid; the code register holds between valid digits.
module bcd_to_2421
   import bcd_codes_pkg::*;
(
   input logic           clk,
   input logic           rst_n,
   bcd_to_2421_if.slave  bus
);

   code2421_t lut_code;
   logic      lut_invalid;
   code2421_t code_q;
   logic      valid_q;
   logic      err_q;

   bcd2421_lut u_lut (
      .data    (bus.data),
      .code    (lut_code),
      .invalid (lut_invalid)
   );

   // data is only looked at when in_valid is high, so an X on an idle bus never reaches the registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         code_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else if (bus.in_valid) begin
         code_q  <= lut_code;
         valid_q <= 1'b1;
         err_q   <= lut_invalid;
      end else begin
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end
   end

   assign bus.w         = code_q[3];
   assign bus.x         = code_q[2];
   assign bus.y         = code_q[1];
   assign bus.z         = code_q[0];
   assign bus.out_valid = valid_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_to_2421.sv
// Directed + random bench for bcd_to_2421 with a self-complement based reference model.
module tb_bcd_to_2421;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;
   logic [5:0] exp_q[$];

   bcd_to_2421_if bus ();

   bcd_to_2421 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: 0..4 are plain binary (w=0); 5..9 are the complement of code(9-d); others are 0000.
   function automatic logic [3:0] ref_code(input int d);
      logic [3:0] b;
      if (d < 0 || d > 9) return 4'b0000;
      if (d < 5) begin
         b = d[3:0];
         return b;
      end
      return ~ref_code(9 - d);
   endfunction

   function automatic logic [3:0] outs();
      return {bus.w, bus.x, bus.y, bus.z};
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [3:0] d, input logic v);
      bus.data     = d;
      bus.in_valid = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] held;
      logic [3:0] c_lo;
      logic [5:0] e;
      int         d;
      logic       v;

      errors       = 0;
      checks       = 0;
      rst_n        = 1'b0;
      bus.data     = 4'd9;
      bus.in_valid = 1'b1;

      // Reset held with a valid digit present.
      repeat (2) @(posedge clk);
      #1;
      check("reset_code", outs(), 4'b0000);
      check("reset_valid", {3'b0, bus.out_valid}, 4'd0);
      check("reset_err", {3'b0, bus.err}, 4'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_code", outs(), 4'b1111);
      check("post_reset_valid", {3'b0, bus.out_valid}, 4'd1);

      // Sweep of all BCD digits.
      for (int i = 0; i < 10; i++) begin
         step(i[3:0], 1'b1);
         check($sformatf("sweep_code_%0d", i), outs(), ref_code(i));
         check($sformatf("sweep_err_%0d", i), {3'b0, bus.err}, 4'd0);
         check($sformatf("sweep_valid_%0d", i), {3'b0, bus.out_valid}, 4'd1);
      end
      step(4'd4, 1'b1);
      check("table_4", outs(), 4'b0100);
      step(4'd5, 1'b1);
      check("table_5", outs(), 4'b1011);

      // Non-BCD digits.
      for (int i = 10; i < 16; i++) begin
         step(i[3:0], 1'b1);
         check($sformatf("inv_code_%0d", i), outs(), 4'b0000);
         check($sformatf("inv_err_%0d", i), {3'b0, bus.err}, 4'd1);
         check($sformatf("inv_valid_%0d", i), {3'b0, bus.out_valid}, 4'd1);
      end
      step(4'd3, 1'b1);
      check("after_inv_code", outs(), 4'b0011);
      check("after_inv_err", {3'b0, bus.err}, 4'd0);

      // Gap in in_valid: code holds, valid drops.
      step(4'd7, 1'b1);
      check("gap_code_a", outs(), 4'b1101);
      check("gap_valid_a", {3'b0, bus.out_valid}, 4'd1);
      step(4'd2, 1'b0);
      check("gap_code_b", outs(), 4'b1101);
      check("gap_valid_b", {3'b0, bus.out_valid}, 4'd0);
      step(4'd6, 1'b1);
      check("gap_code_c", outs(), 4'b1100);
      check("gap_valid_c", {3'b0, bus.out_valid}, 4'd1);

      // Asynchronous reset pulse between edges.
      step(4'd5, 1'b1);
      check("mid_before", outs(), 4'b1011);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_code", outs(), 4'b0000);
      check("mid_rst_valid", {3'b0, bus.out_valid}, 4'd0);
      #1 rst_n = 1'b1;
      step(4'd6, 1'b1);
      check("mid_resume_code", outs(), 4'b1100);
      check("mid_resume_valid", {3'b0, bus.out_valid}, 4'd1);

      // Self-complement across the DUT.
      for (int i = 0; i < 5; i++) begin
         step(i[3:0], 1'b1);
         c_lo = outs();
         step(4'(9 - i), 1'b1);
         check($sformatf("self_comp_%0d", i), c_lo ^ outs(), 4'b1111);
      end

      // Random traffic, including X on data while idle.
      held = 4'b0000;
      for (int n = 0; n < 60; n++) begin
         d = $urandom_range(0, 15);
         v = (n == 0) || ($urandom_range(0, 3) != 0);
         if (v) begin
            held = ref_code(d);
            exp_q.push_back({held, 1'b1, (d > 9)});
            step(d[3:0], 1'b1);
         end else begin
            exp_q.push_back({held, 1'b0, 1'b0});
            step(($urandom_range(0, 1) != 0) ? 4'bxxxx : d[3:0], 1'b0);
         end
         e = exp_q.pop_front();
         check($sformatf("rand_code_%0d", n), outs(), e[5:2]);
         check($sformatf("rand_valid_%0d", n), {3'b0, bus.out_valid}, {3'b0, e[1]});
         check($sformatf("rand_err_%0d", n), {3'b0, bus.err}, {3'b0, e[0]});
      end

      bus.in_valid = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
